ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the command path toward the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Accepts one byte per valid/ready handshake, inhibits the bus, issues a request-to-send and shifts out data, odd parity and stop bit on device-generated clock edges.
- Checks the device ACK, then reports done or error.
- Sits beside the keyboard receiver on the same kclock/kdata pins. The open-drain enables are combined at the top level. busy lets the receiver ignore bus traffic during a transmit.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_host_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    ERR
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NOSTART = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_NOACK   = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Odd parity bit: makes the total count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter for one PS/2 pin.
// The filtered level only changes after FILTER_LEN consecutive synchronized
// samples disagree with it, which rejects short glitches on the open-drain bus.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] run_cnt;

  // Metastability synchronizer; idles high like the released bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], pin};
  end

  // Count consecutive disagreeing samples; adopt the new level on the last one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
      level   <= 1'b1;
    end else if (sync_q[1] == level) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
      run_cnt <= '0;
      level   <= sync_q[1];
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device falling edges, then check the device ACK.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a byte, bus released
// INHIBIT   | kclock held low; start bit asserted in the final cycle
// REQ       | kclock released, kdata low; waiting for first device edge
// SEND      | driving bits 0..7, parity, stop on successive falling edges
// ACK       | waiting for edge 11 to sample the device ACK
// WAIT_IDLE | waiting for both lines high before reporting done
// ERR       | one-cycle error pulse, bus released
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 12000,
  parameter int START_TIMEOUT_CYCLES = 1500000,
  parameter int FRAME_TIMEOUT_CYCLES = 200000,  // must be >= 2
  parameter int FILTER_LEN           = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclock_in,
  input  logic       kdata_in,
  output logic       kclock_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int SW = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FRAME_TIMEOUT_CYCLES + 1);

  ps2_tx_state_t state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          kdata_drv_q, kdata_drv_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic [FW-1:0] fr_cnt_q, fr_cnt_d;
  logic          kclk_lvl, kdat_lvl, kclk_prev, fall_evt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclock_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (kclock_in),
    .level   (kclk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (kdata_in),
    .level   (kdat_lvl)
  );

  assign fall_evt = kclk_prev & ~kclk_lvl;
  assign err_code = err_code_q;

  // State, datapath and timer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      kdata_drv_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      inh_cnt_q   <= '0;
      st_cnt_q    <= '0;
      fr_cnt_q    <= '0;
      kclk_prev   <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      kdata_drv_q <= kdata_drv_d;
      err_code_q  <= err_code_d;
      inh_cnt_q   <= inh_cnt_d;
      st_cnt_q    <= st_cnt_d;
      fr_cnt_q    <= fr_cnt_d;
      kclk_prev   <= kclk_lvl;
    end
  end

  // Next-state, timers and bus outputs. Outputs decode from registered state
  // so a reset releases both lines without waiting for a clock.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    kdata_drv_d = kdata_drv_q;
    err_code_d  = err_code_q;
    inh_cnt_d   = inh_cnt_q;
    st_cnt_d    = st_cnt_q;
    fr_cnt_d    = fr_cnt_q;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    kclock_oe   = 1'b0;
    kdata_oe    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          shift_d    = {1'b1, odd_parity(tx_data), tx_data};
          bit_idx_d  = '0;
          err_code_d = ERR_NONE;
          inh_cnt_d  = IW'(INHIBIT_CYCLES - 1);
          state_d    = INHIBIT;
        end
      end

      INHIBIT: begin
        kclock_oe = 1'b1;
        if (inh_cnt_q == '0) begin
          kdata_oe = 1'b1;
          st_cnt_d = SW'(START_TIMEOUT_CYCLES - 1);
          state_d  = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - IW'(1);
        end
      end

      REQ: begin
        kdata_oe = 1'b1;
        if (fall_evt) begin
          kdata_drv_d = ~shift_q[0];
          shift_d     = {1'b1, shift_q[9:1]};
          bit_idx_d   = 4'd1;
          // The edge cycle itself counts as the first frame-timer cycle.
          fr_cnt_d    = FW'(FRAME_TIMEOUT_CYCLES - 2);
          state_d     = SEND;
        end else if (st_cnt_q == '0) begin
          err_code_d = ERR_NOSTART;
          state_d    = ERR;
        end else begin
          st_cnt_d = st_cnt_q - SW'(1);
        end
      end

      SEND: begin
        kdata_oe = kdata_drv_q;
        if (fr_cnt_q == '0) begin
          err_code_d = ERR_FRAME;
          state_d    = ERR;
        end else begin
          fr_cnt_d = fr_cnt_q - FW'(1);
          if (fall_evt) begin
            kdata_drv_d = ~shift_q[0];
            shift_d     = {1'b1, shift_q[9:1]};
            bit_idx_d   = bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd9) state_d = ACK;
          end
        end
      end

      ACK: begin
        if (fr_cnt_q == '0) begin
          err_code_d = ERR_FRAME;
          state_d    = ERR;
        end else begin
          fr_cnt_d = fr_cnt_q - FW'(1);
          if (fall_evt) begin
            bit_idx_d = 4'd11;
            if (!kdat_lvl) begin
              state_d = WAIT_IDLE;
            end else begin
              err_code_d = ERR_NOACK;
              state_d    = ERR;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (fr_cnt_q == '0) begin
          err_code_d = ERR_FRAME;
          state_d    = ERR;
        end else begin
          fr_cnt_d = fr_cnt_q - FW'(1);
          if (kclk_lvl && kdat_lvl) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      ERR: begin
        error       = 1'b1;
        kdata_drv_d = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus bit/outcome scoreboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int ST  = 400;
  localparam int FT  = 3000;
  localparam int FL  = 8;
  localparam int H   = 40;   // device clock half period in system cycles

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kclock_in, kdata_in, kclock_oe, kdata_oe;
  logic       busy, done, error;
  logic [1:0] err_code;

  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

  assign kclock_in = dev_clk & ~glitch & ~kclock_oe;
  assign kdata_in  = dev_data & ~kdata_oe;

  typedef struct packed { logic is_err; logic [1:0] code; } outcome_t;
  logic     exp_bits[$];
  logic     obs_bits[$];
  outcome_t exp_out[$];

  int checks = 0, failures = 0;
  int cyc = 0, fall1_cyc = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(ST),
    .FRAME_TIMEOUT_CYCLES(FT), .FILTER_LEN(FL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .kclock_in(kclock_in), .kdata_in(kdata_in),
    .kclock_oe(kclock_oe), .kdata_oe(kdata_oe), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor: pulse counts, error context, inhibit length, REQ entry.
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0, req_cyc = 0;
  int         inh_len = 0, inh_last = 0;
  logic [1:0] err_code_seen = 2'b00;
  logic       err_oe_seen = 1'b0, after_pulse = 1'b0, ready_after = 1'b0;

  always @(negedge clock) begin
    after_pulse <= done | error;
    if (after_pulse) ready_after <= tx_ready;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt       <= err_cnt + 1;
      err_cyc       <= cyc;
      err_code_seen <= err_code;
      err_oe_seen   <= kclock_oe | kdata_oe;
    end
    if (done && error) both_cnt <= both_cnt + 1;
    if (kclock_oe) inh_len <= inh_len + 1;
    else if (inh_len != 0) begin
      inh_last <= inh_len;
      inh_len  <= 0;
      req_cyc  <= cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    while (!tx_ready && n < 5000) begin @(negedge clock); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready tx_ready=%b required=1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Device model: clocks n_edges falling/rising pairs, samples on rising edges.
  task automatic device(input int n_edges, input logic ack);
    int n = 0;
    while (!(busy && !kclock_oe && kdata_oe) && n < INH + 200) begin
      @(negedge clock); n++;
    end
    if (!(busy && !kclock_oe && kdata_oe)) begin
      checks++; failures++;
      $display("FAIL req_wait busy=%b kclock_oe=%b kdata_oe=%b required=1,0,1", busy, kclock_oe, kdata_oe);
      return;
    end
    repeat (20) @(negedge clock);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 1) fall1_cyc = cyc;
      dev_clk = 1'b0;
      repeat (H) @(negedge clock);
      dev_clk = 1'b1;
      if (i <= 10) obs_bits.push_back(kdata_in);
      repeat (H / 2) @(negedge clock);
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
      repeat (H / 2) @(negedge clock);
    end
    dev_data = 1'b1;
  endtask

  task automatic score_bits(input string name);
    logic e, o;
    int   k = 0;
    checks++;
    if (obs_bits.size() != exp_bits.size()) begin
      failures++;
      $display("FAIL %s_bitcount got=%0d required=%0d", name, obs_bits.size(), exp_bits.size());
    end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front();
      o = obs_bits.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_bit%0d got=%b required=%b", name, k, o, e);
      end
      k++;
    end
    exp_bits.delete();
    obs_bits.delete();
  endtask

  task automatic score_outcome(input string name, input int d0, input int e0);
    outcome_t exp;
    int n = 0, exp_done, exp_err;
    while (done_cnt == d0 && err_cnt == e0 && n < 6000) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    exp      = exp_out.pop_front();
    exp_done = exp.is_err ? 0 : 1;
    exp_err  = exp.is_err ? 1 : 0;
    checks++;
    if (done_cnt - d0 != exp_done) begin
      failures++;
      $display("FAIL %s_done got=%0d required=%0d", name, done_cnt - d0, exp_done);
    end
    checks++;
    if (err_cnt - e0 != exp_err) begin
      failures++;
      $display("FAIL %s_error got=%0d required=%0d", name, err_cnt - e0, exp_err);
    end
    if (exp.is_err) begin
      checks++;
      if (err_code_seen !== exp.code) begin
        failures++;
        $display("FAIL %s_err_code got=%b required=%b", name, err_code_seen, exp.code);
      end
      checks++;
      if (err_oe_seen !== 1'b0) begin
        failures++;
        $display("FAIL %s_err_oe got=%b required=0", name, err_oe_seen);
      end
    end
    checks++;
    if (ready_after !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after got=%b required=1", name, ready_after);
    end
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL %s_done_and_error got=%0d required=0", name, both_cnt);
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    repeat (3) @(negedge clock);
    obs = {tx_ready, busy, done, error, kclock_oe, kdata_oe, err_code};
    checks++;
    if (obs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_held outputs=%b required=10000000", obs);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    obs = {tx_ready, busy, done, error, kclock_oe, kdata_oe, err_code};
    checks++;
    if (obs !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_released outputs=%b required=10000000", obs);
    end
  endtask

  task automatic test_nominal();
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_SET_LED);
    push_frame(CMD_SET_LED);
    exp_out.push_back('{1'b0, ERR_NONE});
    device(11, 1'b1);
    checks++;
    if (inh_last != INH) begin
      failures++;
      $display("FAIL nominal_inhibit_len got=%0d required=%0d", inh_last, INH);
    end
    score_bits("nominal");
    score_outcome("nominal", d0, e0);
  endtask

  task automatic test_parity();
    logic [7:0] pat[2];
    int d0, e0;
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      d0 = done_cnt; e0 = err_cnt;
      send_byte(pat[p]);
      push_frame(pat[p]);
      exp_out.push_back('{1'b0, ERR_NONE});
      device(11, 1'b1);
      checks++;
      if (obs_bits.size() < 9 || obs_bits[8] !== 1'b1) begin
        failures++;
        $display("FAIL parity_%02h got=%b required=1", pat[p], obs_bits.size() < 9 ? 1'bx : obs_bits[8]);
      end
      score_bits("parity");
      score_outcome("parity", d0, e0);
    end
  endtask

  task automatic test_no_device();
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_ENABLE);
    exp_out.push_back('{1'b1, ERR_NOSTART});
    score_outcome("nostart", d0, e0);
    checks++;
    if (err_cyc - req_cyc != ST) begin
      failures++;
      $display("FAIL nostart_latency got=%0d required=%0d", err_cyc - req_cyc, ST);
    end
  endtask

  task automatic test_no_ack();
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_RESET);
    push_frame(CMD_RESET);
    exp_out.push_back('{1'b1, ERR_NOACK});
    device(11, 1'b0);
    score_bits("noack");
    score_outcome("noack", d0, e0);
  endtask

  task automatic test_stall();
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(CMD_SET_LED);
    exp_out.push_back('{1'b1, ERR_FRAME});
    device(5, 1'b1);
    obs_bits.delete();
    score_outcome("stall", d0, e0);
    checks++;
    if (err_cyc - fall1_cyc != FT + 2 + FL) begin
      failures++;
      $display("FAIL stall_latency got=%0d required=%0d", err_cyc - fall1_cyc, FT + 2 + FL);
    end
    d0 = done_cnt; e0 = err_cnt;
    send_byte(CMD_ENABLE);
    push_frame(CMD_ENABLE);
    exp_out.push_back('{1'b0, ERR_NONE});
    device(11, 1'b1);
    score_bits("after_stall");
    score_outcome("after_stall", d0, e0);
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    send_byte(CMD_RESET);
    repeat (10) @(negedge clock);
    checks++;
    if (kclock_oe !== 1'b1) begin
      failures++;
      $display("FAIL inhibit_before_reset kclock_oe=%b required=1", kclock_oe);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (kclock_oe !== 1'b0) begin
      failures++;
      $display("FAIL inhibit_reset kclock_oe=%b required=0", kclock_oe);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(CMD_SET_LED);
    device(5, 1'b1);
    obs_bits.delete();
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, kdata_oe} !== 2'b11) begin
      failures++;
      $display("FAIL send_bit4 busy,kdata_oe=%b required=11", {busy, kdata_oe});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({kclock_oe, kdata_oe} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_oe got=%b required=00", {kclock_oe, kdata_oe});
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset_release tx_ready,busy=%b required=10", {tx_ready, busy});
    end
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      failures++;
      $display("FAIL mid_reset_pulses done=%0d error=%0d required=0,0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt, e0 = err_cnt, n = 0;
    send_byte(8'hFF);
    while (!(busy && !kclock_oe && kdata_oe) && n < INH + 200) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    glitch = 1'b1;
    repeat (3) @(negedge clock);
    glitch = 1'b0;
    repeat (30) @(negedge clock);
    checks++;
    if ({busy, kclock_oe, kdata_oe} !== 3'b101) begin
      failures++;
      $display("FAIL glitch_ignored busy,kclock_oe,kdata_oe=%b required=101", {busy, kclock_oe, kdata_oe});
    end
    push_frame(8'hFF);
    exp_out.push_back('{1'b0, ERR_NONE});
    device(11, 1'b1);
    score_bits("glitch");
    score_outcome("glitch", d0, e0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity();
    test_no_device();
    test_no_ack();
    test_stall();
    test_reset_mid();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
